axi_ar_beat_splitter: RTL and testbench
=======================================

Name: axi_ar_beat_splitter

Overview:
- Producer end of the bridge's size/command FIFOs, in the wclk (AXI) domain.
- Accepts one AXI4 read-address transfer at a time and expands it into one command entry per beat (address, size, id, last).
- Pushes each entry into the async command/size FIFOs, honouring their full flag, so the AHB-side reader can issue single transfers.

Parameters:
- ADDR_W, 32, address width of s_araddr and cmd_addr.
- ID_W, 4, width of s_arid and cmd_id.
- MAX_SIZE, 2, largest legal arsize (log2 of data-bus bytes; 2 = 32-bit bus).

Ports:
- wclk  in  1  AXI-domain clock; all logic is posedge wclk.
- resetn  in  1  reset, asynchronous, active-low.
- s_arid  in  ID_W  AR id.
- s_araddr  in  ADDR_W  AR start address.
- s_arlen  in  8  beats minus one.
- s_arsize  in  3  log2 bytes per beat.
- s_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- s_arvalid  in  1  AR valid.
- s_arready  out  1  AR ready.
- cmd_full  in  1  OR of the downstream FIFO full flags.
- cmd_push  out  1  write enable to the FIFOs.
- cmd_addr  out  ADDR_W  beat address.
- cmd_size  out  3  beat size (the FIFO data_in).
- cmd_id  out  ID_W  burst id.
- cmd_last  out  1  final beat of the burst.
- busy  out  1  burst in progress.
- err_pulse  out  1  one-cycle flag for a malformed AR.

Behaviour:
- States: IDLE, BURST. Reset -> IDLE.
- Reset values: s_arready=1, cmd_push=0, busy=0, err_pulse=0; addr, size, id and beat counter all 0.
- Async reset mid-burst drops the remaining beats immediately. No partial entry is pushed.
- IDLE:
  - s_arready=1.
  - On s_arvalid & s_arready, capture id, addr, len, size and burst into registers, load beat_cnt=arlen, go to BURST.
  - The first push can occur the next cycle (AR-to-first-push latency = 1 cycle).
- BURST:
  - s_arready=0, busy=1.
  - cmd_push = !cmd_full. It is combinational, so a FIFO that is full this cycle gets no push.
  - cmd_addr, cmd_size and cmd_id are driven from registers.
  - cmd_last = (beat_cnt==0).
  - When cmd_push=1 and beat_cnt!=0: advance the address and decrement beat_cnt.
  - When cmd_push=1 and beat_cnt==0: go to IDLE.
  - When cmd_full=1: hold all state. There is no limit on stall length.
- Bubble: at least one IDLE cycle between bursts. Back-to-back throughput is (len+1) pushes plus 1 cycle per burst.
- Address arithmetic (ADDR_W bits, inc = 1<<size):
  - FIXED: address is unchanged every beat.
  - INCR: next = (addr & ~(inc-1)) + inc. The first beat keeps the unaligned address; later beats are aligned. Wraps modulo 2^ADDR_W with no error.
  - WRAP: wlen = (len+1)<<size; base = addr & ~(wlen-1); next = base | ((addr+inc) & (wlen-1)). An unaligned start is aligned first, as in INCR, before the wrap mask.
- Error handling (err_pulse asserted the cycle after the AR handshake):
  - s_arburst==11: treated as INCR.
  - WRAP with arlen not in {1,3,7,15}: treated as INCR.
  - s_arsize > MAX_SIZE: size is clamped to MAX_SIZE for both cmd_size and the increment.
- Burst length: arlen=0 produces a single beat with cmd_last=1. arlen=255 produces 256 beats; the counter is 8 bits.
- s_arvalid while BURST is ignored (no ready), so the AR payload must stay stable per AXI.

Test Plan:
- INCR, addr 0x1000, len 3, size 2, cmd_full=0 -> pushes on 4 consecutive cycles starting 1 cycle after the handshake; cmd_addr 0x1000, 0x1004, 0x1008, 0x100C; cmd_last only on the 4th; s_arready returns 1 the cycle after.
- WRAP, addr 0x2038, len 7, size 2 -> cmd_addr 0x38, 0x3C, 0x20, 0x24, 0x28, 0x2C, 0x30, 0x34 (upper bits 0x20xx); no err_pulse.
- INCR, unaligned addr 0x1003, len 2, size 2 -> 0x1003, 0x1004, 0x1008. FIXED, addr 0x40, len 2 -> 0x40 three times.
- INCR len 5, with cmd_full held high on beats 2–3 for 10 cycles -> no push while full; exactly 6 pushes, with no duplicated or skipped address.
- Error cases: WRAP with len 2 -> err_pulse=1 for 1 cycle and INCR addressing. arsize 3 with MAX_SIZE 2 -> cmd_size=2, step 4, err_pulse=1. arburst 11 -> err_pulse=1.
- resetn pulled low on beat 3 of a len-7 burst -> s_arready=1 and cmd_push=0 immediately. A new AR with len 0 afterwards gives one push with cmd_last=1.

Source files
------------

// File: rtl/axi_ar_beat_splitter.sv
// AXI4 read-address splitter: turns one AR burst into per-beat command entries
// pushed into the bridge's async command/size FIFOs in the wclk domain.
module axi_ar_beat_splitter #(
  parameter int ADDR_W   = 32,
  parameter int ID_W     = 4,
  parameter int MAX_SIZE = 2
) (
  input  logic              wclk,
  input  logic              resetn,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic              cmd_full,
  output logic              cmd_push,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [2:0]        cmd_size,
  output logic [ID_W-1:0]   cmd_id,
  output logic              cmd_last,
  output logic              busy,
  output logic              err_pulse
);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [2:0]        MAX_SZ = 3'(MAX_SIZE);
  localparam logic [1:0]        B_FIXED = 2'b00;
  localparam logic [1:0]        B_INCR  = 2'b01;
  localparam logic [1:0]        B_WRAP  = 2'b10;
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_wmask;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [7:0]          r_beat_cnt;
  logic                r_err;

  logic                w_handshake;
  logic                w_push;
  logic                w_size_ok;
  logic                w_wrap_len_ok;
  logic                w_bad_burst;
  logic                w_bad_wrap;
  logic [2:0]          w_cap_size;
  logic [1:0]          w_cap_burst;
  logic                w_cap_err;
  logic [ADDR_W-1:0]   w_cap_wmask;
  logic [ADDR_W-1:0]   w_inc;
  logic [ADDR_W-1:0]   w_aligned;
  logic [ADDR_W-1:0]   w_incr_next;
  logic [ADDR_W-1:0]   w_wrap_next;
  logic [ADDR_W-1:0]   w_addr_next;

  // Sanitise the incoming AR: malformed bursts fall back to INCR, oversize beats clamp.
  always_comb begin
    w_size_ok     = (s_arsize <= MAX_SZ);
    w_cap_size    = w_size_ok ? s_arsize : MAX_SZ;
    w_wrap_len_ok = (s_arlen == 8'd1) || (s_arlen == 8'd3) ||
                    (s_arlen == 8'd7) || (s_arlen == 8'd15);
    w_bad_burst   = (s_arburst == 2'b11);
    w_bad_wrap    = (s_arburst == B_WRAP) && !w_wrap_len_ok;
    w_cap_burst   = (w_bad_burst || w_bad_wrap) ? B_INCR : s_arburst;
    w_cap_err     = w_bad_burst || w_bad_wrap || !w_size_ok;
    w_cap_wmask   = ((ADDR_W'(s_arlen) + ONE) << w_cap_size) - ONE;
  end

  // Next beat address; the wrap path aligns first so an unaligned start behaves like INCR.
  always_comb begin
    w_inc       = ONE << r_size;
    w_aligned   = r_addr & ~(w_inc - ONE);
    w_incr_next = w_aligned + w_inc;
    w_wrap_next = (r_addr & ~r_wmask) | ((w_aligned + w_inc) & r_wmask);
    case (r_burst)
      B_FIXED: w_addr_next = r_addr;
      B_WRAP:  w_addr_next = w_wrap_next;
      default: w_addr_next = w_incr_next;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    s_arready   = 1'b0;
    busy        = 1'b0;
    w_push      = 1'b0;
    cmd_last    = 1'b0;
    case (r_state)
      IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          w_state_nxt = BURST;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BURST: begin
        busy     = 1'b1;
        w_push   = !cmd_full;
        cmd_last = (r_beat_cnt == 8'd0);
        if (w_push && (r_beat_cnt == 8'd0)) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BURST;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_handshake = s_arvalid && s_arready;
  assign cmd_push    = w_push;
  assign cmd_addr    = r_addr;
  assign cmd_size    = r_size;
  assign cmd_id      = r_id;
  assign err_pulse   = r_err;

  // State register.
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Burst context: captured on the AR handshake, stepped on each accepted push.
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      r_id       <= '0;
      r_addr     <= '0;
      r_wmask    <= '0;
      r_size     <= 3'd0;
      r_burst    <= 2'b00;
      r_beat_cnt <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_handshake && w_cap_err;
      if (w_handshake) begin
        r_id       <= s_arid;
        r_addr     <= s_araddr;
        r_wmask    <= w_cap_wmask;
        r_size     <= w_cap_size;
        r_burst    <= w_cap_burst;
        r_beat_cnt <= s_arlen;
      end else if (w_push && (r_beat_cnt != 8'd0)) begin
        r_addr     <= w_addr_next;
        r_beat_cnt <= r_beat_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_ar_beat_splitter.sv
// Directed bench for axi_ar_beat_splitter: hand-computed beat address lists,
// stall, error and mid-burst reset cases checked with immediate assertions.
module tb_axi_ar_beat_splitter;

  logic        wclk;
  logic        resetn;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arvalid;
  logic        s_arready;
  logic        cmd_full;
  logic        cmd_push;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [3:0]  cmd_id;
  logic        cmd_last;
  logic        busy;
  logic        err_pulse;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  axi_ar_beat_splitter #(.ADDR_W(32), .ID_W(4), .MAX_SIZE(2)) dut (
    .wclk(wclk), .resetn(resetn),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .cmd_full(cmd_full), .cmd_push(cmd_push), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .cmd_id(cmd_id), .cmd_last(cmd_last), .busy(busy), .err_pulse(err_pulse)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one AR and follow the burst; cmd_full is high for st_len cycles from cycle st_start.
  task automatic run_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [2:0] exp_size, input logic exp_err,
                           input int st_start, input int st_len);
    int n;
    int k;
    int c;
    n = exp_q.size();
    k = 0;
    c = 0;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    cmd_full  = 1'b0;
    #1;
    chk({tag, "/arready_idle"}, 32'(s_arready), 32'd1);
    cyc();
    s_arvalid = 1'b0;
    while (k < n && c < 64) begin
      cmd_full = (c >= st_start) && (c < st_start + st_len);
      #1;
      if (c == 0) begin
        chk({tag, "/err_pulse"}, 32'(err_pulse), 32'(exp_err));
        chk({tag, "/busy"}, 32'(busy), 32'd1);
        chk({tag, "/arready_busy"}, 32'(s_arready), 32'd0);
      end
      if (c == 1) chk({tag, "/err_one_cycle"}, 32'(err_pulse), 32'd0);
      chk({tag, "/push"}, 32'(cmd_push), 32'(!cmd_full));
      if (cmd_push) begin
        chk($sformatf("%s/addr%0d", tag, k), cmd_addr, exp_q[k]);
        chk($sformatf("%s/last%0d", tag, k), 32'(cmd_last), 32'(k == n - 1));
        chk($sformatf("%s/size%0d", tag, k), 32'(cmd_size), 32'(exp_size));
        chk($sformatf("%s/id%0d", tag, k), 32'(cmd_id), 32'(id));
        k++;
      end
      cyc();
      c++;
    end
    cmd_full = 1'b0;
    chk({tag, "/beats"}, 32'(k), 32'(n));
    chk({tag, "/cycles"}, 32'(c), 32'(n + st_len));
    #1;
    chk({tag, "/arready_after"}, 32'(s_arready), 32'd1);
    chk({tag, "/busy_after"}, 32'(busy), 32'd0);
    chk({tag, "/push_after"}, 32'(cmd_push), 32'd0);
    cyc();
  endtask

  initial begin
    resetn = 1'b0; cmd_full = 1'b0; s_arvalid = 1'b0;
    s_arid = 4'd0; s_araddr = 32'd0; s_arlen = 8'd0; s_arsize = 3'd0; s_arburst = 2'b00;
    cyc(); cyc();
    chk("rst/arready", 32'(s_arready), 32'd1);
    chk("rst/push", 32'(cmd_push), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/err", 32'(err_pulse), 32'd0);
    chk("rst/addr", cmd_addr, 32'd0);
    chk("rst/size", 32'(cmd_size), 32'd0);
    chk("rst/id", 32'(cmd_id), 32'd0);
    resetn = 1'b1;
    cyc();

    exp_q = {32'h1000, 32'h1004, 32'h1008, 32'h100C};
    run_burst("incr4", 4'd1, 32'h1000, 8'd3, 3'd2, 2'b01, 3'd2, 1'b0, 0, 0);

    exp_q = {32'h2038, 32'h203C, 32'h2020, 32'h2024, 32'h2028, 32'h202C, 32'h2030, 32'h2034};
    run_burst("wrap8", 4'd2, 32'h2038, 8'd7, 3'd2, 2'b10, 3'd2, 1'b0, 0, 0);

    exp_q = {32'h1003, 32'h1004, 32'h1008};
    run_burst("incr_unal", 4'd3, 32'h1003, 8'd2, 3'd2, 2'b01, 3'd2, 1'b0, 0, 0);

    exp_q = {32'h40, 32'h40, 32'h40};
    run_burst("fixed", 4'd4, 32'h40, 8'd2, 3'd2, 2'b00, 3'd2, 1'b0, 0, 0);

    exp_q = {32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014};
    run_burst("stall", 4'd5, 32'h3000, 8'd5, 3'd2, 2'b01, 3'd2, 1'b0, 2, 10);

    exp_q = {32'h100, 32'h104, 32'h108};
    run_burst("wrap_badlen", 4'd6, 32'h100, 8'd2, 3'd2, 2'b10, 3'd2, 1'b1, 0, 0);

    exp_q = {32'h200, 32'h204};
    run_burst("size_clamp", 4'd7, 32'h200, 8'd1, 3'd3, 2'b01, 3'd2, 1'b1, 0, 0);

    exp_q = {32'h300, 32'h304};
    run_burst("burst11", 4'd8, 32'h300, 8'd1, 3'd2, 2'b11, 3'd2, 1'b1, 0, 0);

    exp_q = {32'hFFFF_FFFC, 32'h0000_0000};
    run_burst("incr_wrap32", 4'd9, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 3'd2, 1'b0, 0, 0);

    exp_q = {32'h20, 32'h22, 32'h24, 32'h26};
    run_burst("wrap_h", 4'd10, 32'h20, 8'd3, 3'd1, 2'b10, 3'd1, 1'b0, 0, 0);

    // Mid-burst reset on the third beat of a len-7 INCR burst.
    s_arid = 4'd11; s_araddr = 32'h5000; s_arlen = 8'd7; s_arsize = 3'd2; s_arburst = 2'b01;
    s_arvalid = 1'b1;
    cyc();
    s_arvalid = 1'b0;
    cyc(); cyc();
    #1;
    chk("mrst/push_before", 32'(cmd_push), 32'd1);
    chk("mrst/addr_before", cmd_addr, 32'h5008);
    resetn = 1'b0;
    #1;
    chk("mrst/arready", 32'(s_arready), 32'd1);
    chk("mrst/push", 32'(cmd_push), 32'd0);
    chk("mrst/busy", 32'(busy), 32'd0);
    chk("mrst/addr", cmd_addr, 32'd0);
    cyc();
    resetn = 1'b1;
    cyc();

    exp_q = {32'h600};
    run_burst("len0", 4'd12, 32'h600, 8'd0, 3'd2, 2'b01, 3'd2, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
